// File: rtl/vx_commit_wb_arbiter.sv
// Commit writeback arbiter: per-source commit FIFOs, round-robin pick of one
// commit per cycle, registered register-file write port and a retirement counter.
module vx_commit_wb_arbiter #(
  parameter int NUM_INPUTS  = 3,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 6,
  parameter int UUID_BITS   = 44,
  parameter int BUF_DEPTH   = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_INPUTS-1:0]               in_valid,
  output logic [NUM_INPUTS-1:0]               in_ready,
  input  logic [NUM_INPUTS*UUID_BITS-1:0]     in_uuid,
  input  logic [NUM_INPUTS*NW_BITS-1:0]       in_wid,
  input  logic [NUM_INPUTS*NUM_THREADS-1:0]   in_tmask,
  input  logic [NUM_INPUTS*32-1:0]            in_PC,
  input  logic [NUM_INPUTS*NR_BITS-1:0]       in_rd,
  input  logic [NUM_INPUTS-1:0]               in_wb,
  input  logic [NUM_INPUTS-1:0]               in_eop,
  input  logic [NUM_INPUTS*NUM_THREADS*32-1:0] in_data,
  output logic                                wb_valid,
  output logic [UUID_BITS-1:0]                wb_uuid,
  output logic [NW_BITS-1:0]                  wb_wid,
  output logic [NUM_THREADS-1:0]              wb_tmask,
  output logic [31:0]                         wb_PC,
  output logic [NR_BITS-1:0]                  wb_rd,
  output logic [NUM_THREADS*32-1:0]           wb_data,
  output logic [63:0]                         retire_count
);

  localparam int DW      = NUM_THREADS * 32;
  localparam int EOP_BIT = DW;
  localparam int WB_BIT  = DW + 1;
  localparam int RD_LO   = DW + 2;
  localparam int PC_LO   = RD_LO + NR_BITS;
  localparam int TM_LO   = PC_LO + 32;
  localparam int WID_LO  = TM_LO + NUM_THREADS;
  localparam int UUID_LO = WID_LO + NW_BITS;
  localparam int EW      = UUID_LO + UUID_BITS;
  localparam int AW      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW      = $clog2(BUF_DEPTH + 1);
  localparam int PW      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  // Handshake: a beat transfers on source i when in_valid[i] & in_ready[i] at a
  // rising edge; in_ready depends only on registered FIFO occupancy.
  logic [NUM_INPUTS-1:0] w_push;
  logic [NUM_INPUTS-1:0] w_pop;
  logic [NUM_INPUTS-1:0] w_nonempty;
  logic [EW-1:0]         w_heads [NUM_INPUTS];
  logic [EW-1:0]         w_head;
  logic                  w_grant_valid;
  logic [PW-1:0]         w_grant_idx;
  logic [PW:0]           w_scan;
  logic [PW-1:0]         r_ptr;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_fifo
    logic [EW-1:0] r_mem [BUF_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [EW-1:0] w_in_entry;

    assign w_in_entry = {in_uuid[i*UUID_BITS +: UUID_BITS], in_wid[i*NW_BITS +: NW_BITS],
                         in_tmask[i*NUM_THREADS +: NUM_THREADS], in_PC[i*32 +: 32],
                         in_rd[i*NR_BITS +: NR_BITS], in_wb[i], in_eop[i], in_data[i*DW +: DW]};
    assign in_ready[i]   = (r_count != CW'(BUF_DEPTH));
    assign w_push[i]     = in_valid[i] & in_ready[i];
    assign w_nonempty[i] = (r_count != '0);
    assign w_heads[i]    = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push[i]) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop[i])  r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_push[i] && !w_pop[i])      r_count <= r_count + CW'(1);
        else if (!w_push[i] && w_pop[i]) r_count <= r_count - CW'(1);
      end
    end

    // Payload storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
      if (w_push[i]) r_mem[r_wr_ptr] <= w_in_entry;
    end
  end

  // Scan sources starting at the round-robin pointer; first non-empty wins.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    w_scan        = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      w_scan = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_scan >= (PW+1)'(NUM_INPUTS)) w_scan = w_scan - (PW+1)'(NUM_INPUTS);
      if (!w_grant_valid && w_nonempty[w_scan[PW-1:0]]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = w_scan[PW-1:0];
      end
    end
  end

  always_comb begin
    w_pop = '0;
    if (w_grant_valid) w_pop[w_grant_idx] = 1'b1;
  end

  assign w_head = w_heads[w_grant_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_grant_valid) begin
      r_ptr <= (w_grant_idx == PW'(NUM_INPUTS - 1)) ? '0 : w_grant_idx + PW'(1);
    end
  end

  // Fields only load on a real write so the port holds its last write otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid     <= 1'b0;
      wb_uuid      <= '0;
      wb_wid       <= '0;
      wb_tmask     <= '0;
      wb_PC        <= '0;
      wb_rd        <= '0;
      wb_data      <= '0;
      retire_count <= '0;
    end else begin
      wb_valid <= w_grant_valid & w_head[WB_BIT];
      if (w_grant_valid && w_head[WB_BIT]) begin
        wb_uuid  <= w_head[UUID_LO +: UUID_BITS];
        wb_wid   <= w_head[WID_LO +: NW_BITS];
        wb_tmask <= w_head[TM_LO +: NUM_THREADS];
        wb_PC    <= w_head[PC_LO +: 32];
        wb_rd    <= w_head[RD_LO +: NR_BITS];
        wb_data  <= w_head[DW-1:0];
      end
      if (w_grant_valid && w_head[EOP_BIT]) retire_count <= retire_count + 64'd1;
    end
  end

endmodule

// File: doc/vx_commit_wb_arbiter.md
Name: vx_commit_wb_arbiter

Overview:
- Sits directly downstream of the ALU execute unit and its sibling execute units (LSU, CSR).
- Buffers each unit's commit stream in a small per-input FIFO.
- Arbitrates round-robin among the FIFOs, one commit per cycle, and drives a registered writeback port into the register file.
- Maintains a retired-instruction counter for performance CSRs.

Parameters:
- NUM_INPUTS, 3, number of commit sources (index 0 = ALU, 1 = LSU, 2 = CSR)
- NUM_THREADS, 4, lanes per warp
- NW_BITS, 2, warp id width
- NR_BITS, 6, register id width
- UUID_BITS, 44, instruction uuid width
- BUF_DEPTH, 2, entries per input FIFO (power of two, ≥2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- in_valid  in  NUM_INPUTS  per-source commit valid
- in_ready  out  NUM_INPUTS  per-source accept
- in_uuid  in  NUM_INPUTS*UUID_BITS  uuid
- in_wid  in  NUM_INPUTS*NW_BITS  warp id
- in_tmask  in  NUM_INPUTS*NUM_THREADS  thread mask
- in_PC  in  NUM_INPUTS*32  PC
- in_rd  in  NUM_INPUTS*NR_BITS  destination register
- in_wb  in  NUM_INPUTS  writeback enable
- in_eop  in  NUM_INPUTS  end of packet (last beat of instruction)
- in_data  in  NUM_INPUTS*NUM_THREADS*32  per-lane result
- wb_valid  out  1  register-file write strobe
- wb_uuid  out  UUID_BITS  uuid of written instruction
- wb_wid  out  NW_BITS  warp id
- wb_tmask  out  NUM_THREADS  lane write mask
- wb_PC  out  32  PC (trace only)
- wb_rd  out  NR_BITS  register id
- wb_data  out  NUM_THREADS*32  write data
- retire_count  out  64  instructions retired (eop pops)

Behaviour:
- Clock is clk; reset is asynchronous and active-high.
- Reset:
  - FIFOs are emptied.
  - wb_valid=0; all other wb_* outputs are 0.
  - retire_count=0; round-robin pointer=0.
  - in_ready goes to all-ones on the first cycle after reset deasserts.
  - Assertion mid-operation discards all buffered entries without writeback.
- Input handshake:
  - Push on in_valid[i] & in_ready[i].
  - in_ready[i] = ~full[i], derived from the registered count only, so there is no combinational path from in_valid or from arbitration.
  - Simultaneous push and pop on the same FIFO are legal when not full; occupancy is unchanged.
- Arbitration:
  - Each cycle, among non-empty FIFOs, grant the first index ≥ ptr, wrapping modulo NUM_INPUTS.
  - The granted FIFO head is popped.
  - ptr ← grant+1 modulo NUM_INPUTS; ptr holds when nothing is granted.
  - At most one pop per cycle.
- Output register:
  - On a grant, the wb_* fields load from the popped head; wb_valid ← head.wb.
  - With no grant, or when head.wb=0: wb_valid ← 0 and the data fields hold.
  - The register file always accepts, so there is no backpressure on wb.
- Latency:
  - Push at the edge ending cycle t → head visible in t+1.
  - If granted in t+1, wb_valid is high in t+2.
  - Minimum latency is 2 cycles; there is no bypass.
- Throughput: 1 commit/cycle aggregate; a single source with BUF_DEPTH=2 sustains 1/cycle when uncontested.
- Retirement:
  - retire_count increments by 1 on every pop with head.eop=1, whether or not wb=1.
  - Wraps modulo 2^64.
- Ordering: FIFO order within a source is preserved; there is no ordering guarantee across sources.
- tmask=0 with wb=1: wb_valid still asserts with tmask=0. The register file performs no lane writes.

Test Plan:
- Reset mid-stream: fill ALU FIFO with 2 entries, assert reset → wb_valid=0 next cycle, retire_count=0, entries never appear, in_ready=3'b111 after release.
- Single source latency: ALU push uuid=5, rd=3, data=0x1234 lane0, wb=1, eop=1 at cycle 0 → wb_valid=1, wb_rd=3, wb_data[0]=0x1234 at cycle 2; retire_count=1.
- Round-robin fairness: all three sources valid every cycle for 9 cycles → grants 0,1,2,0,1,2,… and each source gets 3 writebacks in 9 cycles.
- Backpressure: ALU pushes every cycle while LSU and CSR are continuously non-empty → in_ready[0] drops to 0 once the ALU FIFO holds 2 entries, and no ALU entry is lost or reordered.
- No-writeback commit: CSR push wb=0, eop=1 → no wb_valid pulse and retire_count increments by 1.
- Multi-beat: LSU pushes 2 entries with eop=0 then eop=1 → two wb_valid pulses and retire_count increments by 1 only.
